// File: rtl/gat_bram_load_ctrl_if.sv
// Host write / core BRAM write bundle for the multi-channel load controller.
// The master side drives host writes; the slave side returns trimmed BRAM writes.
interface gat_bram_load_ctrl_if #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned TOP_WIDTH = 32,
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned ADDR_W    = 18
);
    logic [NUM_CH*TOP_WIDTH-1:0]  host_din;
    logic [NUM_CH-1:0]            host_ena;
    logic [NUM_CH-1:0]            host_wea;
    logic [NUM_CH*(ADDR_W+2)-1:0] host_addra;
    logic [NUM_CH*DATA_W-1:0]     bram_din;
    logic [NUM_CH-1:0]            bram_we;
    logic [NUM_CH*ADDR_W-1:0]     bram_addr;

    modport master (
        output host_din, host_ena, host_wea, host_addra,
        input  bram_din, bram_we, bram_addr
    );

    modport slave (
        input  host_din, host_ena, host_wea, host_addra,
        output bram_din, bram_we, bram_addr
    );
endinterface

// File: rtl/gat_bram_load_ctrl.sv
// Host-to-core BRAM load controller: forwards trimmed word-addressed writes per channel,
// tracks load completion, launches one core run and blocks host writes while it runs.
module gat_bram_load_ctrl #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned TOP_WIDTH = 32,
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned CNT_W     = 20,
    localparam int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gat_bram_load_ctrl_if.slave    bus,
    input  logic [NUM_CH-1:0]      host_load_done,
    input  logic                   gat_layer,
    input  logic                   core_done,
    input  logic [SEL_W-1:0]       dbg_sel,
    output logic                   core_start,
    output logic                   core_layer,
    output logic                   gat_ready,
    output logic [CNT_W-1:0]       dbg_count,
    output logic [1:0]             err_flags
);

    localparam int unsigned HA_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LAUNCH = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    core_start_q;
    logic                    core_layer_q;
    logic                    gat_ready_q;
    logic [NUM_CH-1:0]       we_q;
    logic [NUM_CH*ADDR_W-1:0] addr_q;
    logic [NUM_CH*DATA_W-1:0] din_q;
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [NUM_CH-1:0]       done_q;
    logic [NUM_CH-1:0]       ld_prev_q;
    logic [1:0]              err_q;
    logic [CNT_W-1:0]        dbg_q;

    logic                    run_c;
    logic                    exit_run_c;
    logic [NUM_CH-1:0]       req_c;
    logic [NUM_CH-1:0]       accept_c;
    logic [NUM_CH-1:0]       done_rise_c;
    logic                    misalign_c;
    logic [NUM_CH-1:0]       unused_din_c;

    // Upper host data bits are not forwarded to the core.
    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_unused
        assign unused_din_c[gc] = ^bus.host_din[gc*TOP_WIDTH+DATA_W +: TOP_WIDTH-DATA_W];
    end

    always_comb begin
        run_c       = (state_q == RUN);
        exit_run_c  = run_c & core_done;
        req_c       = bus.host_ena & bus.host_wea;
        accept_c    = req_c & {NUM_CH{~run_c}};
        done_rise_c = host_load_done & ~ld_prev_q;
        misalign_c  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept_c[c] && (bus.host_addra[c*HA_W +: 2] != 2'b00)) begin
                misalign_c = 1'b1;
            end
        end
    end

    // Write path, counters, done latches and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            done_q    <= '0;
            ld_prev_q <= '0;
            err_q     <= '0;
            dbg_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            ld_prev_q <= host_load_done;
            we_q      <= accept_c;
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept_c[c]) begin
                    addr_q[c*ADDR_W +: ADDR_W] <= bus.host_addra[c*HA_W+2 +: ADDR_W];
                    din_q[c*DATA_W +: DATA_W]  <= bus.host_din[c*TOP_WIDTH +: DATA_W];
                end
                if (exit_run_c) begin
                    cnt_q[c] <= '0;
                end else if (accept_c[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
                if (exit_run_c) begin
                    done_q[c] <= 1'b0;
                end else if (done_rise_c[c]) begin
                    done_q[c] <= 1'b1;
                end
            end
            err_q[0] <= err_q[0] | misalign_c;
            err_q[1] <= err_q[1] | ((|req_c) & run_c);
            dbg_q    <= (32'(dbg_sel) < NUM_CH) ? cnt_q[dbg_sel] : '0;
        end
    end

    // Run-control FSM with registered launch pulse, layer latch and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            core_layer_q <= 1'b0;
            gat_ready_q  <= 1'b1;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((|accept_c) || (|done_q)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (&done_q) begin
                        state_q      <= LAUNCH;
                        core_start_q <= 1'b1;
                        core_layer_q <= gat_layer;
                        gat_ready_q  <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        state_q     <= IDLE;
                        gat_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gat_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.bram_we   = we_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign core_start    = core_start_q;
    assign core_layer    = core_layer_q;
    assign gat_ready     = gat_ready_q;
    assign dbg_count     = dbg_q;
    assign err_flags     = err_q;

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Scoreboard bench for gat_bram_load_ctrl: expected BRAM writes and launches are queued
// by the stimulus and popped by an independent monitor; status outputs are checked directly.
module tb_gat_bram_load_ctrl;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned TOP_WIDTH = 32;
    localparam int unsigned DATA_W    = 20;
    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned HA_W      = ADDR_W + 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NUM_CH-1:0] host_load_done = '0;
    logic             gat_layer = 1'b0;
    logic             core_done = 1'b0;
    logic [1:0]       dbg_sel = '0;
    logic             core_start;
    logic             core_layer;
    logic             gat_ready;
    logic [CNT_W-1:0] dbg_count;
    logic [1:0]       err_flags;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t  exp_q [NUM_CH][$];
    logic launch_q [$];

    gat_bram_load_ctrl_if #(
        .NUM_CH(NUM_CH), .TOP_WIDTH(TOP_WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) ifc ();

    gat_bram_load_ctrl #(
        .NUM_CH(NUM_CH), .TOP_WIDTH(TOP_WIDTH), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (ifc.slave),
        .host_load_done (host_load_done),
        .gat_layer      (gat_layer),
        .core_done      (core_done),
        .dbg_sel        (dbg_sel),
        .core_start     (core_start),
        .core_layer     (core_layer),
        .gat_ready      (gat_ready),
        .dbg_count      (dbg_count),
        .err_flags      (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int c, input logic [HA_W-1:0] addr,
                      input logic [TOP_WIDTH-1:0] din, input bit expect_fwd);
        wr_t e;
        ifc.host_ena[c] = 1'b1;
        ifc.host_wea[c] = 1'b1;
        ifc.host_addra[c*HA_W +: HA_W]        = addr;
        ifc.host_din[c*TOP_WIDTH +: TOP_WIDTH] = din;
        if (expect_fwd) begin
            e.addr = addr[HA_W-1:2];
            e.din  = din[DATA_W-1:0];
            exp_q[c].push_back(e);
        end
        step();
        ifc.host_ena[c] = 1'b0;
        ifc.host_wea[c] = 1'b0;
    endtask

    task automatic wait_launch();
        for (int i = 0; i < 10 && launch_q.size() != 0; i++) step();
        chk("launch_pending", 32'(launch_q.size()), 32'd0);
    endtask

    task automatic chk_dbg(input logic [1:0] sel, input logic [31:0] exp, input string nm);
        dbg_sel = sel;
        step();
        step();
        chk(nm, 32'(dbg_count), exp);
    endtask

    // Monitor: pop expected BRAM writes / launches whenever the DUT presents one.
    initial begin
        wr_t e;
        logic l;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ifc.bram_we[c]) begin
                        n_cmp++;
                        if (exp_q[c].size() == 0) begin
                            n_bad++;
                            $display("FAIL bram_we_unexpected ch%0d: addr %0h din %0h, expected no write",
                                     c, ifc.bram_addr[c*ADDR_W +: ADDR_W], ifc.bram_din[c*DATA_W +: DATA_W]);
                        end else begin
                            e = exp_q[c].pop_front();
                            if (ifc.bram_addr[c*ADDR_W +: ADDR_W] !== e.addr ||
                                ifc.bram_din[c*DATA_W +: DATA_W] !== e.din) begin
                                n_bad++;
                                $display("FAIL bram_wr ch%0d: got addr %0h din %0h, expected addr %0h din %0h",
                                         c, ifc.bram_addr[c*ADDR_W +: ADDR_W],
                                         ifc.bram_din[c*DATA_W +: DATA_W], e.addr, e.din);
                            end
                        end
                    end
                end
                if (core_start) begin
                    n_cmp++;
                    if (launch_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL core_start_unexpected: got 1, expected 0");
                    end else begin
                        l = launch_q.pop_front();
                        if (core_layer !== l) begin
                            n_bad++;
                            $display("FAIL core_layer: got %0b, expected %0b", core_layer, l);
                        end
                    end
                end
            end
        end
    end

    initial begin
        ifc.host_ena   = '0;
        ifc.host_wea   = '0;
        ifc.host_addra = '0;
        ifc.host_din   = '0;

        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_gat_ready", 32'(gat_ready), 32'd1);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_bram_we", 32'(ifc.bram_we), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_dbg", 32'(dbg_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic forwarding and misalignment flag.
        wr(0, 20'h10, 32'hABCDE123, 1'b1);
        wr(1, 20'h13, 32'h00012345, 1'b1);
        step();
        chk("err_misalign", 32'(err_flags), 32'd1);

        // Bring totals to 5/2/3 words.
        for (int i = 1; i < 5; i++) wr(0, 20'(32'h10 + 4 * i), 32'(i), 1'b1);
        wr(1, 20'h20, 32'hFFF0_0AAA, 1'b1);
        for (int i = 0; i < 3; i++) wr(2, 20'(32'h100 + 4 * i), 32'(32'h7000 + i), 1'b1);
        chk_dbg(2'd0, 32'd5, "dbg_ch0");
        chk_dbg(2'd1, 32'd2, "dbg_ch1");
        chk_dbg(2'd2, 32'd3, "dbg_ch2");
        chk_dbg(2'd3, 32'd0, "dbg_sel_oob");
        chk("ready_load", 32'(gat_ready), 32'd1);

        // Launch: all done edges at once.
        gat_layer = 1'b0;
        launch_q.push_back(1'b0);
        host_load_done = 3'b111;
        wait_launch();
        step();
        chk("ready_run", 32'(gat_ready), 32'd0);
        chk_dbg(2'd0, 32'd5, "dbg_run_ch0");

        // Write during RUN is dropped and flagged.
        wr(2, 20'h40, 32'h12345678, 1'b0);
        step();
        chk("err_run_write", 32'(err_flags), 32'd3);
        chk_dbg(2'd2, 32'd3, "dbg_run_ch2");

        host_load_done = '0;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        chk("ready_after_done", 32'(gat_ready), 32'd1);
        chk("dbg_cleared", 32'(dbg_count), 32'd0);
        chk("err_sticky", 32'(err_flags), 32'd3);

        // Last done edge coincides with a write; layer 1 latched at launch.
        wr(0, 20'h0, 32'h00011111, 1'b1);
        wr(1, 20'h4, 32'h00022222, 1'b1);
        host_load_done = 3'b011;
        step();
        gat_layer = 1'b1;
        launch_q.push_back(1'b1);
        host_load_done[2] = 1'b1;
        wr(2, 20'h8, 32'hFFF33333, 1'b1);
        wait_launch();
        step();
        chk("core_layer_held", 32'(core_layer), 32'd1);
        chk_dbg(2'd2, 32'd1, "dbg_coinc_ch2");

        // Asynchronous reset in the middle of RUN.
        host_load_done = '0;
        gat_layer = 1'b0;
        step();
        chk("ready_run2", 32'(gat_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_gat_ready", 32'(gat_ready), 32'd1);
        chk("arst_core_layer", 32'(core_layer), 32'd0);
        chk("arst_err", 32'(err_flags), 32'd0);
        chk("arst_bram_we", 32'(ifc.bram_we), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Counter saturation at 2^CNT_W-1.
        for (int i = 0; i < 17; i++) wr(0, 20'(4 * i), 32'(32'h500 + i), 1'b1);
        chk_dbg(2'd0, 32'd15, "dbg_saturated");
        chk("no_start_after_rst", 32'(core_start), 32'd0);

        step();
        chk("queues_drained",
            32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + launch_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
